systolic_feed_sequencer: RTL

//  Streams one tile of cfg_len data vectors from an operand buffer into the

---
 rtl/systolic_feed_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_feed_sequencer.sv
// systolic_feed_sequencer
// Streams one tile of cfg_len vectors from an operand buffer into a DEPTH-stage
// systolic skew chain. Source stalls become zero bubbles on the feed. A
// DEPTH-deep {valid,last} tag line runs alongside the chain, so out_valid and
// out_last line up with the chain's data_out. done pulses once the final vector
// has left the chain.
// Optional feature: define SEQ_STALL_CNT_EN to build the saturating
// source-stall counter. Without it, stall_cycles is tied to zero.

module systolic_feed_sequencer #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  cfg_len,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0] feed_data,
    output logic                  feed_valid,
    output logic                  feed_last,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Drain counter must be able to hold the value DEPTH.
    localparam int DRAIN_W = $clog2(DEPTH + 1);

    logic [1:0]            state_q,      state_d;
    logic [CNT_WIDTH-1:0]  len_q,        len_d;
    logic [CNT_WIDTH-1:0]  beat_q,       beat_d;
    logic [DRAIN_W-1:0]    drain_q,      drain_d;
    logic [DATA_WIDTH-1:0] feed_data_q,  feed_data_d;
    logic                  feed_valid_q, feed_valid_d;
    logic                  feed_last_q,  feed_last_d;
    logic [DEPTH-1:0]      tag_valid_q,  tag_valid_d;
    logic [DEPTH-1:0]      tag_last_q,   tag_last_d;

    // Sequencer FSM: issues beats, inserts bubbles on stalls, waits for the drain.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        beat_d       = beat_q;
        drain_d      = drain_q;
        feed_data_d  = '0;
        feed_valid_d = 1'b0;
        feed_last_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            len_d   = cfg_len;
                            beat_d  = '0;
                            state_d = S_STREAM;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_STREAM: begin
                    if (src_valid) begin
                        feed_data_d  = src_data;
                        feed_valid_d = 1'b1;
                        beat_d       = beat_q + CNT_WIDTH'(1);
                        if (beat_q == len_q - CNT_WIDTH'(1)) begin
                            feed_last_d = 1'b1;
                            drain_d     = '0;
                            state_d     = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // DEPTH+1 cycles from the edge that registered the final beat.
                    if (drain_q == DRAIN_W'(DEPTH)) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Tag line mirrors the downstream chain; abort flushes it so stale data is flagged invalid.
    always_comb begin
        tag_valid_d = '0;
        tag_last_d  = '0;
        if (!abort) begin
            tag_valid_d[0] = feed_valid_q;
            tag_last_d[0]  = feed_last_q;
            for (int i = 1; i < DEPTH; i++) begin
                tag_valid_d[i] = tag_valid_q[i-1];
                tag_last_d[i]  = tag_last_q[i-1];
            end
        end
    end

    // State, feed and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            beat_q       <= '0;
            drain_q      <= '0;
            feed_data_q  <= '0;
            feed_valid_q <= 1'b0;
            feed_last_q  <= 1'b0;
            tag_valid_q  <= '0;
            tag_last_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            drain_q      <= drain_d;
            feed_data_q  <= feed_data_d;
            feed_valid_q <= feed_valid_d;
            feed_last_q  <= feed_last_d;
            tag_valid_q  <= tag_valid_d;
            tag_last_q   <= tag_last_d;
        end
    end

`ifdef SEQ_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    // Saturating stall counter: cleared on an accepted tile start, held afterwards.
    always_comb begin
        stall_d = stall_q;
        if (!abort) begin
            if (state_q == S_IDLE && start) begin
                stall_d = '0;
            end else if (state_q == S_STREAM && !src_valid && stall_q != '1) begin
                stall_d = stall_q + CNT_WIDTH'(1);
            end
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign src_ready  = (state_q == S_STREAM);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign feed_data  = feed_data_q;
    assign feed_valid = feed_valid_q;
    assign feed_last  = feed_last_q;
    assign out_valid  = tag_valid_q[DEPTH-1];
    assign out_last   = tag_last_q[DEPTH-1];

endmodule
